// File: rtl/addsub_pipe_pkg.sv
// Shared constants and the per-stage payload record for the chunked add/sub pipeline.
// Vector fields are sized for the widest supported operand; unused upper bits stay zero.
package addsub_pipe_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;
  localparam int MAX_WIDTH      = 64;

  // Each stage consumes its own chunk of aHi/bxHi and fills in its chunk of sumLo.
  typedef struct packed {
    logic [MAX_WIDTH-1:0] aHi;
    logic [MAX_WIDTH-1:0] bxHi;
    logic [MAX_WIDTH-1:0] sumLo;
    logic                 carry;
    logic                 valid;
  } stage_t;

endpackage

// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe; master drives operands and out_ready.
interface addsub_pipe_if #(
  parameter int WIDTH = addsub_pipe_pkg::DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );

endinterface

// File: rtl/addsub_stage.sv
// One CW-bit chunk adder with its pipeline register and valid/ready handshake.
// Stage IDX adds chunk IDX using the carry registered by the previous stage.
module addsub_stage
  import addsub_pipe_pkg::*;
#(
  parameter int CW  = 8,
  parameter int IDX = 0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  stage_t inPayload_i,
  input  logic   downReady_i,
  output logic   ready_o,
  output stage_t outPayload_o
);

  stage_t                 data_q;
  logic                   valid_d;
  logic                   load;
  logic [CW-1:0]          chunkSum;
  logic                   chunkCarry;
  logic [MAX_WIDTH-1:0]   sumLo_d;

  always_comb begin
    {chunkCarry, chunkSum} = {1'b0, inPayload_i.aHi[IDX*CW +: CW]}
                           + {1'b0, inPayload_i.bxHi[IDX*CW +: CW]}
                           + {{CW{1'b0}}, inPayload_i.carry};
    sumLo_d                  = inPayload_i.sumLo;
    sumLo_d[IDX*CW +: CW]    = chunkSum;
  end

  // The stage can take new data when empty or when its contents leave this cycle.
  always_comb begin
    ready_o = !data_q.valid || downReady_i;
    load    = inPayload_i.valid && ready_o;
    valid_d = ready_o ? inPayload_i.valid : data_q.valid;
  end

  // Data fields only move on a real load, so bubbles never disturb held values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q.valid <= valid_d;
      if (load) begin
        data_q.aHi   <= inPayload_i.aHi;
        data_q.bxHi  <= inPayload_i.bxHi;
        data_q.sumLo <= sumLo_d;
        data_q.carry <= chunkCarry;
      end
    end
  end

  assign outPayload_o = data_q;

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined adder/subtractor: WIDTH split into STAGES chunks, one chunk per stage,
// carry rippling through stage registers with full valid/ready backpressure.
module addsub_pipe
  import addsub_pipe_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic         clk,
  input  logic         rst_n,
  addsub_pipe_if.slave bus
);

  localparam int CW = WIDTH / STAGES;

  stage_t           headP;
  stage_t           tailP;
  stage_t           outP  [STAGES];
  logic             ready [STAGES];
  logic [WIDTH-1:0] bx;
  logic             seen_q;
  logic             seen_d;
  logic             unusedBits;

  // Subtract is a + ~b + 1; a borrow-in turns the +1 into +0.
  always_comb begin
    bx          = bus.sub ? ~bus.b : bus.b;
    headP       = '0;
    headP.aHi   = MAX_WIDTH'(bus.a);
    headP.bxHi  = MAX_WIDTH'(bx);
    headP.carry = bus.cin ^ bus.sub;
    headP.valid = bus.in_valid;
  end

  for (genvar k = 0; k < STAGES; k++) begin : gStage
    stage_t inP;
    logic   downReady;

    if (k == 0) begin : gFirst
      assign inP = headP;
    end else begin : gNext
      assign inP = outP[k-1];
    end

    if (k == STAGES - 1) begin : gLast
      assign downReady = bus.out_ready;
    end else begin : gInner
      assign downReady = ready[k+1];
    end

    addsub_stage #(
      .CW  (CW),
      .IDX (k)
    ) uStage (
      .clk          (clk),
      .rst_n        (rst_n),
      .inPayload_i  (inP),
      .downReady_i  (downReady),
      .ready_o      (ready[k]),
      .outPayload_o (outP[k])
    );
  end

  assign tailP = outP[STAGES-1];

  // zero stays low until a first result has been presented after reset.
  assign seen_d = seen_q || tailP.valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen_q <= 1'b0;
    end else begin
      seen_q <= seen_d;
    end
  end

  assign bus.in_ready  = ready[0];
  assign bus.out_valid = tailP.valid;
  assign bus.sum       = tailP.sumLo[WIDTH-1:0];
  assign bus.cout      = tailP.carry;
  assign bus.ovf       = (tailP.aHi[WIDTH-1] == tailP.bxHi[WIDTH-1])
                      && (tailP.sumLo[WIDTH-1] != tailP.aHi[WIDTH-1]);
  assign bus.zero      = seen_d && (tailP.sumLo[WIDTH-1:0] == '0);

  assign unusedBits = ^{tailP.aHi, tailP.bxHi, tailP.sumLo};

endmodule

// File: tb/tb_addsub_pipe.sv
// Randomized self-checking bench for addsub_pipe in three configurations (32/4, 8/1, 16/8),
// compared against an arithmetic reference model and a FIFO scoreboard.
module tb_addsub_pipe;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  int vectors     = 0;
  int miscompares = 0;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] smallA;
  logic [15:0] smallB;
  logic        smallSub;
  logic        smallCin;
  logic        smallValid;

  addsub_pipe_if #(.WIDTH(32)) bus32 ();
  addsub_pipe_if #(.WIDTH(8))  bus8  ();
  addsub_pipe_if #(.WIDTH(16)) bus16 ();

  addsub_pipe #(.WIDTH(32), .STAGES(4)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  addsub_pipe #(.WIDTH(8),  .STAGES(1)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  addsub_pipe #(.WIDTH(16), .STAGES(8)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  assign bus8.in_valid   = smallValid;
  assign bus8.a          = smallA[7:0];
  assign bus8.b          = smallB[7:0];
  assign bus8.sub        = smallSub;
  assign bus8.cin        = smallCin;
  assign bus8.out_ready  = 1'b1;
  assign bus16.in_valid  = smallValid;
  assign bus16.a         = smallA;
  assign bus16.b         = smallB;
  assign bus16.sub       = smallSub;
  assign bus16.cin       = smallCin;
  assign bus16.out_ready = 1'b1;

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: plain integer arithmetic; overflow means the signed result leaves the range.
  function automatic res_t refModel(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input logic sub, input logic cin);
    res_t   r;
    longint modW, half, aU, bU, bxU, c0, total, sa, sbx, st;
    modW   = longint'(1) << w;
    half   = modW / 2;
    aU     = longint'(a) % modW;
    bU     = longint'(b) % modW;
    bxU    = sub ? (modW - 1 - bU) : bU;
    c0     = (cin ^ sub) ? 1 : 0;
    total  = aU + bxU + c0;
    r.sum  = 32'(total % modW);
    r.cout = (total >= modW);
    sa     = (aU  >= half) ? aU  - modW : aU;
    sbx    = (bxU >= half) ? bxU - modW : bxU;
    st     = sa + sbx + c0;
    r.ovf  = (st >= half) || (st < -half);
    r.zero = ((total % modW) == 0);
    return r;
  endfunction

  task automatic driveMain(input logic v, input logic [31:0] av, input logic [31:0] bv,
                           input logic s, input logic c, input logic r);
    bus32.in_valid  = v;
    bus32.a         = av;
    bus32.b         = bv;
    bus32.sub       = s;
    bus32.cin       = c;
    bus32.out_ready = r;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    vectors++;
    if ({bus32.out_valid, bus32.in_ready, bus32.cout, bus32.ovf, bus32.zero} !== 5'b01000) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got {ov,ir,co,ovf,z}=%b, required 01000",
               {bus32.out_valid, bus32.in_ready, bus32.cout, bus32.ovf, bus32.zero});
    end
    vectors++;
    if (bus32.sum !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_sum: got %h, required 00000000", bus32.sum);
    end
    vectors++;
    if ({bus8.out_valid, bus8.in_ready, bus16.out_valid, bus16.in_ready} !== 4'b0101) begin
      miscompares++;
      $display("[TB] FAIL reset_small: got %b, required 0101",
               {bus8.out_valid, bus8.in_ready, bus16.out_valid, bus16.in_ready});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] tA   [4] = '{32'h0000_0005, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0003};
    logic [31:0] tB   [4] = '{32'h0000_0003, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0003};
    logic        tSub [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic        tCin [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] tSum [4] = '{32'h0000_0008, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [2:0]  tFlg [4] = '{3'b000, 3'b101, 3'b010, 3'b000};
    int lat;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      driveMain(1'b1, tA[i], tB[i], tSub[i], tCin[i], 1'b1);
      #1;
      vectors++;
      if (bus32.in_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL directed_in_ready[%0d]: got %b, required 1", i, bus32.in_ready);
      end
      @(negedge clk);
      driveMain(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      #1;
      lat = 1;
      while (!bus32.out_valid && lat < 20) begin
        @(negedge clk);
        #1;
        lat++;
      end
      vectors++;
      if (lat !== 4) begin
        miscompares++;
        $display("[TB] FAIL directed_latency[%0d]: got %0d cycles, required 4", i, lat);
      end
      vectors++;
      if (bus32.sum !== tSum[i]) begin
        miscompares++;
        $display("[TB] FAIL directed_sum[%0d]: got %h, required %h", i, bus32.sum, tSum[i]);
      end
      vectors++;
      if ({bus32.cout, bus32.ovf, bus32.zero} !== tFlg[i]) begin
        miscompares++;
        $display("[TB] FAIL directed_flags[%0d]: got {co,ovf,z}=%b, required %b", i,
                 {bus32.cout, bus32.ovf, bus32.zero}, tFlg[i]);
      end
    end
  endtask

  task automatic test_throughput();
    res_t expQ[$];
    res_t exp;
    int   first = -1;
    int   last  = -1;
    int   got   = 0;
    logic [31:0] av, bv;
    logic s, c;
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(negedge clk);
      av = $urandom;
      bv = $urandom;
      s  = 1'($urandom_range(0, 1));
      c  = 1'($urandom_range(0, 1));
      driveMain(cyc < 12, av, bv, s, c, 1'b1);
      #1;
      if (bus32.out_valid) begin
        exp = expQ.pop_front();
        vectors++;
        if ({bus32.sum, bus32.cout, bus32.ovf, bus32.zero} !== exp) begin
          miscompares++;
          $display("[TB] FAIL throughput_result: got %h/%b%b%b, required %h/%b%b%b", bus32.sum,
                   bus32.cout, bus32.ovf, bus32.zero, exp.sum, exp.cout, exp.ovf, exp.zero);
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (cyc < 12) begin
        vectors++;
        if (bus32.in_ready !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL throughput_in_ready: got %b at cycle %0d, required 1", bus32.in_ready, cyc);
        end
        expQ.push_back(refModel(32, av, bv, s, c));
      end
    end
    vectors++;
    if (got !== 12 || first !== 4 || last !== 15) begin
      miscompares++;
      $display("[TB] FAIL throughput_timing: got %0d results in cycles %0d..%0d, required 12 in 4..15",
               got, first, last);
    end
  endtask

  task automatic test_back_to_back();
    res_t        expQ[$];
    res_t        exp;
    int          sent    = 0;
    int          got     = 0;
    logic        stalled = 1'b0;
    logic [35:0] held    = '0;
    logic [31:0] av, bv;
    logic        s, c, r;
    av = $urandom; bv = $urandom; s = 1'($urandom_range(0, 1)); c = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
      @(negedge clk);
      r = 1'($urandom_range(0, 1));
      driveMain(sent < 16, av, bv, s, c, r);
      #1;
      if (stalled) begin
        vectors++;
        if ({bus32.out_valid, bus32.sum, bus32.cout, bus32.ovf, bus32.zero} !== held) begin
          miscompares++;
          $display("[TB] FAIL stall_hold: got %h, required %h",
                   {bus32.out_valid, bus32.sum, bus32.cout, bus32.ovf, bus32.zero}, held);
        end
      end
      stalled = bus32.out_valid && !r;
      held    = {bus32.out_valid, bus32.sum, bus32.cout, bus32.ovf, bus32.zero};
      if (bus32.out_valid && r) begin
        vectors++;
        if (expQ.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL b2b_spurious: got extra result %h, required none", bus32.sum);
        end else begin
          exp = expQ.pop_front();
          if ({bus32.sum, bus32.cout, bus32.ovf, bus32.zero} !== exp) begin
            miscompares++;
            $display("[TB] FAIL b2b_result[%0d]: got %h/%b%b%b, required %h/%b%b%b", got, bus32.sum,
                     bus32.cout, bus32.ovf, bus32.zero, exp.sum, exp.cout, exp.ovf, exp.zero);
          end
        end
        got++;
      end
      if (sent < 16 && bus32.in_ready) begin
        expQ.push_back(refModel(32, av, bv, s, c));
        sent++;
        av = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        bv = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
        s  = 1'($urandom_range(0, 1));
        c  = 1'($urandom_range(0, 1));
      end
    end
    vectors++;
    if (got !== 16 || expQ.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL b2b_count: got %0d results (%0d pending), required 16 (0 pending)",
               got, expQ.size());
    end
  endtask

  task automatic test_reset_midflight();
    int ghosts = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      driveMain(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b1);
    end
    @(negedge clk);
    driveMain(1'b1, 32'h1234_5678, 32'h1, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if ({bus32.out_valid, bus32.in_ready} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL midflight_handshake: got {ov,ir}=%b, required 01",
               {bus32.out_valid, bus32.in_ready});
    end
    vectors++;
    if ({bus32.sum, bus32.cout, bus32.ovf, bus32.zero} !== 35'h0) begin
      miscompares++;
      $display("[TB] FAIL midflight_outputs: got %h/%b%b%b, required 0/000", bus32.sum,
               bus32.cout, bus32.ovf, bus32.zero);
    end
    rst_n = 1'b1;
    driveMain(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      #1;
      if (bus32.out_valid) ghosts++;
    end
    vectors++;
    if (ghosts !== 0) begin
      miscompares++;
      $display("[TB] FAIL midflight_ghosts: got %0d results after reset, required 0", ghosts);
    end
  endtask

  task automatic test_small_configs();
    res_t q8[$];
    res_t q16[$];
    int   s8[$];
    int   s16[$];
    res_t exp;
    int   stamp;
    for (int cyc = 0; cyc < 72; cyc++) begin
      @(negedge clk);
      smallValid = (cyc < 60);
      smallA     = (cyc == 0) ? 16'hFFFF : (cyc == 1) ? 16'h7F7F : 16'($urandom);
      smallB     = (cyc == 0) ? 16'h0001 : (cyc == 1) ? 16'hFFFF : 16'($urandom);
      smallSub   = (cyc == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      smallCin   = (cyc < 2) ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      if (bus8.out_valid) begin
        exp   = q8.pop_front();
        stamp = s8.pop_front();
        vectors++;
        if (cyc - stamp !== 1 || {bus8.sum, bus8.cout, bus8.ovf, bus8.zero} !== {exp.sum[7:0], exp.cout, exp.ovf, exp.zero}) begin
          miscompares++;
          $display("[TB] FAIL w8s1_result: got %h/%b%b%b lat %0d, required %h/%b%b%b lat 1", bus8.sum,
                   bus8.cout, bus8.ovf, bus8.zero, cyc - stamp, exp.sum[7:0], exp.cout, exp.ovf, exp.zero);
        end
      end
      if (bus16.out_valid) begin
        exp   = q16.pop_front();
        stamp = s16.pop_front();
        vectors++;
        if (cyc - stamp !== 8 || {bus16.sum, bus16.cout, bus16.ovf, bus16.zero} !== {exp.sum[15:0], exp.cout, exp.ovf, exp.zero}) begin
          miscompares++;
          $display("[TB] FAIL w16s8_result: got %h/%b%b%b lat %0d, required %h/%b%b%b lat 8", bus16.sum,
                   bus16.cout, bus16.ovf, bus16.zero, cyc - stamp, exp.sum[15:0], exp.cout, exp.ovf, exp.zero);
        end
      end
      if (smallValid) begin
        vectors++;
        if ({bus8.in_ready, bus16.in_ready} !== 2'b11) begin
          miscompares++;
          $display("[TB] FAIL small_in_ready: got %b, required 11", {bus8.in_ready, bus16.in_ready});
        end
        q8.push_back(refModel(8, {16'h0, smallA}, {16'h0, smallB}, smallSub, smallCin));
        q16.push_back(refModel(16, {16'h0, smallA}, {16'h0, smallB}, smallSub, smallCin));
        s8.push_back(cyc);
        s16.push_back(cyc);
      end
    end
    smallValid = 1'b0;
    vectors++;
    if (q8.size() !== 0 || q16.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL small_drain: got %0d/%0d pending, required 0/0", q8.size(), q16.size());
    end
  endtask

  initial begin
    smallValid = 1'b0;
    smallA     = '0;
    smallB     = '0;
    smallSub   = 1'b0;
    smallCin   = 1'b0;
    driveMain(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    test_reset();
    test_directed();
    test_throughput();
    test_back_to_back();
    test_reset_midflight();
    test_small_configs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
